// File: rtl/adder64_arbiter.sv
// adder64_arbiter: arbitrates NREQ requesters onto one external 64-bit adder (IDLE/EXEC/RESP).
// Define ADDER64_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module adder64_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*64-1:0] req_b,
  input  logic [NREQ-1:0]    req_cin,
  output logic [63:0]      add_a,
  output logic [63:0]      add_b,
  output logic             add_cin,
  input  logic [63:0]      add_sum,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [63:0]      rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [63:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic cin_q, cin_d, cout_q, cout_d;
  logic [IDW-1:0] id_q, id_d, gnt, idx;
  logic any;
`ifdef ADDER64_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'(k);
      if (req_valid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] ptr_q, ptr_d;
  // scan downward from the farthest offset so the nearest valid index at/after ptr wins
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && any) ptr_d = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
`endif
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    id_d      = id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    req_ready = '0;
    if (state_q == IDLE && any) begin
      req_ready[gnt] = 1'b1;
      a_d            = req_a[int'(gnt)*64 +: 64];
      b_d            = req_b[int'(gnt)*64 +: 64];
      cin_d          = req_cin[gnt];
      id_d           = gnt;
      state_d        = EXEC;
    end
    if (state_q == EXEC) begin
      sum_d   = add_sum;
      cout_d  = add_cout;
      state_d = RESP;
    end
    if (state_q == RESP && rsp_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_adder64_arbiter.sv
// tb_adder64_arbiter: directed self-checking bench; models the external adder combinationally.
module tb_adder64_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid = '0;
  logic [3:0] req_ready;
  logic [255:0] req_a = '0;
  logic [255:0] req_b = '0;
  logic [3:0] req_cin = '0;
  logic [63:0] add_a, add_b, add_sum, rsp_sum;
  logic add_cin, add_cout, rsp_valid, rsp_cout, busy;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [63:0] held_sum;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

  adder64_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_a", add_a, 64'd0);
    chk("rst_sum", rsp_sum, 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    #1;
    chk("idle_no_req_ready", 64'(req_ready), 64'd0);
    step();
    chk("idle_stays", 64'(busy), 64'd0);

`ifdef ADDER64_ARB_FIXED_PRIO_EN
    req_a[64 +: 64] = 64'd10; req_b[64 +: 64] = 64'd5;
    req_a[192 +: 64] = 64'd100; req_b[192 +: 64] = 64'd1;
    req_valid = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("fp_grant1", 64'(req_ready), 64'b0010);
      step();
      step();
      chk("fp_id1", 64'(rsp_id), 64'd1);
      chk("fp_sum1", rsp_sum, 64'd15);
      step();
    end
    req_valid = 4'b1000;
    #1;
    chk("fp_grant3", 64'(req_ready), 64'b1000);
    step();
    req_valid = 4'b0000;
    step();
    chk("fp_id3", 64'(rsp_id), 64'd3);
    chk("fp_sum3", rsp_sum, 64'd101);
    step();
`else
    // single op with full carry-out
    req_a[0 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF; req_b[0 +: 64] = 64'd1; req_cin[0] = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = 4'b0000;
    #1;
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_no_valid", 64'(rsp_valid), 64'd0);
    chk("exec_add_a", add_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("exec_add_b", add_b, 64'd1);
    step();
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_sum", rsp_sum, 64'd0);
    chk("single_cout", 64'(rsp_cout), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd0);
    step();
    chk("single_done", 64'(rsp_valid), 64'd0);
    chk("single_idle", 64'(busy), 64'd0);
    // carry-in on requester 2; pointer now 1
    req_a[128 +: 64] = 64'h7FFF_FFFF_FFFF_FFFF; req_b[128 +: 64] = 64'd0; req_cin[2] = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("cin_ready", 64'(req_ready), 64'b0100);
    step();
    req_valid = 4'b0000;
    step();
    chk("cin_sum", rsp_sum, 64'h8000_0000_0000_0000);
    chk("cin_cout", 64'(rsp_cout), 64'd0);
    chk("cin_id", 64'(rsp_id), 64'd2);
    step();
    // reset during EXEC; pointer is now 3
    req_a[192 +: 64] = 64'd7; req_b[192 +: 64] = 64'd8;
    req_valid = 4'b1000;
    #1;
    chk("rstx_ready", 64'(req_ready), 64'b1000);
    step();
    req_valid = 4'b0000;
    chk("rstx_exec", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstx_busy", 64'(busy), 64'd0);
    chk("rstx_add_a", add_a, 64'd0);
    chk("rstx_sum", rsp_sum, 64'd0);
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      chk("rstx_no_rsp", 64'(rsp_valid), 64'd0);
      step();
    end
    // round-robin from pointer 0 with all four valid
    req_a[0 +: 64]   = 64'h1111_1111_1111_1111; req_b[0 +: 64]   = 64'd1; req_cin[0] = 1'b0;
    req_a[64 +: 64]  = 64'h2222_2222_2222_2222; req_b[64 +: 64]  = 64'd2; req_cin[1] = 1'b1;
    req_a[128 +: 64] = 64'h3333_3333_3333_3333; req_b[128 +: 64] = 64'd3; req_cin[2] = 1'b0;
    req_a[192 +: 64] = 64'hFFFF_FFFF_FFFF_FFF0; req_b[192 +: 64] = 64'h20; req_cin[3] = 1'b1;
    req_valid = 4'b1111;
    begin
      logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [63:0] sums [4] = '{64'h1111_1111_1111_1112, 64'h2222_2222_2222_2225,
                               64'h3333_3333_3333_3336, 64'h0000_0000_0000_0011};
      logic couts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int n = 0; n < 5; n++) begin
        #1;
        chk("rr_grant", 64'(req_ready), 64'(4'b0001 << order[n]));
        step();
        chk("rr_exec_ready", 64'(req_ready), 64'd0);
        step();
        chk("rr_id", 64'(rsp_id), 64'(order[n]));
        chk("rr_sum", rsp_sum, sums[order[n]]);
        chk("rr_cout", 64'(rsp_cout), 64'(couts[order[n]]));
        step();
      end
    end
    // backpressure on requester 1's response
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 64'(req_ready), 64'b0010);
    step();
    step();
    held_sum = 64'h2222_2222_2222_2225;
    for (int n = 0; n < 5; n++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_sum", rsp_sum, held_sum);
      chk("bp_id", 64'(rsp_id), 64'd1);
      chk("bp_no_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_released", 64'(rsp_valid), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'b0100);
    req_valid = 4'b0000;
    step();
    step();
    step();
`endif
    chk("end_idle", 64'(busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adder64_arbiter.md
ADDER64_ARBITER -- requirements
Module: adder64_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter IDW, default 2, meaning rsp_id width, with IDW = clog2(NREQ).
REQ-003 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 The block SHALL have port req_ready  output  NREQ  per-requester accept strobe.
REQ-007 The block SHALL have port req_a  input  NREQ*64  packed operand A, requester i at [i*64 +: 64].
REQ-008 The block SHALL have port req_b  input  NREQ*64  packed operand B, same packing.
REQ-009 The block SHALL have port req_cin  input  NREQ  per-requester carry-in.
REQ-010 The block SHALL have port add_a, add_b  output  64 each  operands to the external 64-bit carry-lookahead adder.
REQ-011 The block SHALL have port add_cin  output  1  adder carry-in.
REQ-012 The block SHALL have port add_sum  input  64  adder sum, combinational from add_a/add_b/add_cin.
REQ-013 The block SHALL have port add_cout  input  1  adder carry-out.
REQ-014 The block SHALL have port rsp_valid  output  1  result available.
REQ-015 The block SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-016 The block SHALL have port rsp_id  output  IDW  index of the requester that owns the result.
REQ-017 The block SHALL have port rsp_sum  output  64  registered sum.
REQ-018 The block SHALL have port rsp_cout  output  1  registered carry-out.
REQ-019 The block SHALL have port busy  output  1  high in states EXEC and RESP.

Function
REQ-020 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-021 In IDLE with any req_valid high, the FSM SHALL assert req_ready for exactly one granted index g, latch req_a/req_b/req_cin of g and g into internal registers, and move to EXEC on the next edge.
REQ-022 req_ready SHALL be combinational from state, req_valid and the pointer, one-hot or zero, and zero outside IDLE.
REQ-023 Requests SHALL be level-held: a requester holds valid and operands until it sees ready; dropping valid before grant SHALL be legal and ignored.
REQ-024 In IDLE with no req_valid, the FSM SHALL stay in IDLE and keep all req_ready low.
REQ-025 add_a/add_b/add_cin SHALL be driven only from the latched operand registers, so they are stable during EXEC.
REQ-026 In EXEC the FSM SHALL capture add_sum/add_cout into rsp_sum/rsp_cout and move to RESP, spending exactly one cycle in EXEC.
REQ-027 In RESP rsp_valid SHALL be 1; rsp_sum/rsp_cout/rsp_id SHALL stay stable until rsp_valid&rsp_ready.
REQ-028 On rsp_valid&rsp_ready the FSM SHALL go to IDLE, and rsp_valid SHALL be 0 the next cycle.
REQ-029 Latency SHALL be: accept in cycle N gives rsp_valid in cycle N+2; best-case throughput is one operation per 3 cycles.
REQ-030 Round-robin arbitration SHALL grant the first valid index at or above the pointer, wrapping NREQ-1 to 0.
REQ-031 After each grant g, the pointer SHALL become (g+1) mod NREQ.
REQ-032 Requests arriving during EXEC/RESP SHALL wait and be arbitrated in the next IDLE cycle.
REQ-033 Sum arithmetic SHALL be modulo 2^64, with carry-out exactly add_cout.
REQ-034 Operand and result registers SHALL hold their values when unused.

Reset
REQ-035 rst_n low SHALL asynchronously force: state IDLE, pointer 0, rsp_valid 0, busy 0, rsp_sum 0, rsp_cout 0, rsp_id 0, operand registers 0 (so add_a=add_b=0, add_cin=0).
REQ-036 Reset mid-operation SHALL discard the in-flight operation with no response, and the requester SHALL NOT be re-acknowledged.
REQ-037 First grant after reset release SHALL follow REQ-030 from pointer 0.

Configuration
REQ-038 With macro ADDER64_ARB_FIXED_PRIO_EN defined, grant SHALL be to the lowest valid index, the pointer SHALL be absent and all other behaviour SHALL be unchanged.
REQ-039 With ADDER64_ARB_FIXED_PRIO_EN undefined, arbitration SHALL be round-robin per REQ-030/031.

Verification
REQ-040 Single op: req_valid=4'b0001, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> req_ready[0] cycle N, rsp_valid at N+2, sum=0, cout=1, id=0.
REQ-041 Round-robin: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-042 Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, no req_ready, busy=1, and the next grant comes one cycle after release.
REQ-043 Carry-in: a=64'h7FFF_FFFF_FFFF_FFFF, b=0, cin=1 on requester 2 -> sum=64'h8000_0000_0000_0000, cout=0, id=2.
REQ-044 Reset during EXEC: rst_n low for 1 cycle -> rsp_valid never rises for that op, and state/pointer read back as 0.
REQ-045 ADDER64_ARB_FIXED_PRIO_EN defined: requesters 1 and 3 held valid -> requester 1 always wins, and requester 3 is granted only after 1 drops.
